// File: rtl/rbm_approx_accum.sv
// Weighted-sum accumulator for one RBM unit: folds gated 16-bit weights into acc
// through a segmented approximate adder (or an exact one), then offers the sum downstream.

// Segmented approximate adder: 4-bit windows overlapping by 2 bits, carry-in guessed from A.
module iadder_B16_4B (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s
);
  assign s[3:0] = a[3:0] + b[3:0];

  // Each window keeps only its upper two sum bits; the low two only feed its carry.
  for (genvar k = 2; k <= 12; k += 2) begin : g_seg
    assign s[k+3:k+2] = 2'((a[k+3:k] + b[k+3:k] + {3'd0, a[k-2]}) >> 2);
  end
endmodule

module rbm_approx_accum #(
  parameter int N_TERMS = 16,
  parameter bit EXACT   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_w,
  input  logic        in_v,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        busy
);
  localparam int CW = $clog2(N_TERMS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   acc, sum;
  logic [CW-1:0] cnt;
  logic          hs, clr, last;

  // Operand order matters for the approximate adder: A is the running sum.
  if (EXACT) begin : g_exact
    assign sum = acc + in_w;
  end else begin : g_approx
    iadder_B16_4B u_add (.a(acc), .b(in_w), .s(sum));
  end

  assign last    = (cnt == CW'(N_TERMS - 1));
  assign out_sum = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs depend on state only, so in_ready/out_valid never see in_valid/out_ready combinationally.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    hs        = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          clr       = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        hs       = in_valid && !abort;
        if (hs && last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // acc survives abort on purpose; only a fresh start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (hs) begin
      if (in_v) acc <= sum;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rbm_approx_accum.sv
// Bench for rbm_approx_accum: three instances (N=4 approx, N=2 exact, N=1 approx) checked
// every cycle against a transaction-level model, plus directed literal expectations.
module tb_rbm_approx_accum;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ND-1:0]       start, abort, in_valid, in_ready, in_v, out_valid, out_ready, busy;
  logic [ND-1:0][15:0] in_w, out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    rbm_approx_accum #(
      .N_TERMS(g == 0 ? 4 : (g == 1 ? 2 : 1)),
      .EXACT  (g == 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .abort    (abort[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_w     (in_w[g]),
      .in_v     (in_v[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_sum  (out_sum[g]),
      .busy     (busy[g])
    );
  end

  function automatic int nt(int d);
    return d == 0 ? 4 : (d == 1 ? 2 : 1);
  endfunction

  // Reference ADD straight from the arithmetic definition.
  function automatic logic [15:0] add_m(logic [15:0] a, logic [15:0] b, bit ex);
    logic [15:0] s;
    int t;
    if (ex) return a + b;
    s[3:0] = 4'((int'(a[3:0]) + int'(b[3:0])) % 16);
    for (int k = 2; k <= 12; k += 2) begin
      t = int'(a[k+:4]) + int'(b[k+:4]) + int'(a[k-2]);
      s[k+2+:2] = 2'((t / 4) % 4);
    end
    return s;
  endfunction

  task automatic chk(string nm, int d, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 collecting terms, 2 holding result.
  int          m_ph [ND];
  int          m_cnt[ND];
  logic [15:0] m_acc[ND];

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        m_ph[d] = 0; m_cnt[d] = 0; m_acc[d] = 16'h0;
      end
      chk("in_ready",  d, 16'(in_ready[d]),  16'(m_ph[d] == 1));
      chk("out_valid", d, 16'(out_valid[d]), 16'(m_ph[d] == 2));
      chk("busy",      d, 16'(busy[d]),      16'(m_ph[d] != 0));
      chk("out_sum",   d, out_sum[d],        m_acc[d]);
      if (rst_n) begin
        if (abort[d]) m_ph[d] = 0;
        else if (m_ph[d] == 0 && start[d]) begin
          m_ph[d] = 1; m_cnt[d] = 0; m_acc[d] = 16'h0;
        end else if (m_ph[d] == 1 && in_valid[d]) begin
          if (in_v[d]) m_acc[d] = add_m(m_acc[d], in_w[d], d == 1);
          m_cnt[d]++;
          if (m_cnt[d] == nt(d)) m_ph[d] = 2;
        end else if (m_ph[d] == 2 && out_ready[d]) m_ph[d] = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic go(int d);
    start[d] = 1'b1; step(); start[d] = 1'b0;
  endtask

  task automatic feed(int d, logic [15:0] w, logic v);
    in_valid[d] = 1'b1; in_w[d] = w; in_v[d] = v; step();
  endtask

  task automatic wait_done(int d, logic [15:0] exp, string nm);
    bit seen = 0;
    in_valid[d] = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = out_valid[d];
    end
    if (!seen) chk({nm, "_timeout"}, d, 16'd0, 16'd1);
    else       chk(nm, d, out_sum[d], exp);
  endtask

  task automatic accept(int d);
    step();
    out_ready[d] = 1'b1; step(); out_ready[d] = 1'b0;
  endtask

  initial begin
    start = '0; abort = '0; in_valid = '0; in_v = '0; out_ready = '0; in_w = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Async reset mid-accumulation, observed before any clock edge.
    go(0); feed(0, 16'h0005, 1'b1); feed(0, 16'h0003, 1'b1); in_valid[0] = 1'b0;
    #2 rst_n = 1'b0; #1;
    chk("rst_out_valid", 0, 16'(out_valid[0]), 16'd0);
    chk("rst_in_ready",  0, 16'(in_ready[0]),  16'd0);
    chk("rst_busy",      0, 16'(busy[0]),      16'd0);
    chk("rst_out_sum",   0, out_sum[0],        16'h0000);
    step(); rst_n = 1'b1; step();

    // w=1,2,3,4 back-to-back, approximate.
    go(0);
    for (int i = 1; i <= 4; i++) feed(0, 16'(i), 1'b1);
    wait_done(0, 16'h000A, "sum_1234");
    accept(0);

    // Carry-guess case: approx loses the carries, exact keeps them.
    go(0); feed(0, 16'h000F, 1'b1); feed(0, 16'h00F1, 1'b1);
    feed(0, 16'hFFFF, 1'b0); feed(0, 16'hFFFF, 1'b0);
    wait_done(0, 16'h0000, "approx_f_f1");
    accept(0);
    go(1); feed(1, 16'h000F, 1'b1); feed(1, 16'h00F1, 1'b1);
    wait_done(1, 16'h0100, "exact_f_f1");
    accept(1);

    // Gated terms with in_valid toggling, then a long stall in DONE with stray starts.
    go(0);
    for (int i = 0; i < 4; i++) begin
      feed(0, 16'h0010, (i % 2) == 0); in_valid[0] = 1'b0; step();
    end
    wait_done(0, 16'h0020, "gated");
    for (int i = 0; i < 10; i++) begin
      start[0] = (i % 3) == 0; step();
      chk("stall_sum", 0, out_sum[0], 16'h0020);
      chk("stall_vld", 0, 16'(out_valid[0]), 16'd1);
    end
    start[0] = 1'b0;
    out_ready[0] = 1'b1; step(); out_ready[0] = 1'b0;
    chk("idle_after_accept", 0, 16'(busy[0]), 16'd0);

    // Abort after 2 of 4 terms, with a handshake offered in the abort cycle.
    go(0); feed(0, 16'h0100, 1'b1); feed(0, 16'h0100, 1'b1);
    abort[0] = 1'b1; feed(0, 16'h0100, 1'b1); abort[0] = 1'b0; in_valid[0] = 1'b0;
    chk("abort_busy", 0, 16'(busy[0]), 16'd0);
    chk("abort_acc",  0, out_sum[0], 16'h0200);
    go(0);
    for (int i = 0; i < 4; i++) feed(0, 16'h0001, 1'b1);
    wait_done(0, 16'h0004, "after_abort");
    accept(0);

    // start and abort together in IDLE: abort wins.
    start[0] = 1'b1; abort[0] = 1'b1; step(); start[0] = 1'b0; abort[0] = 1'b0;
    chk("start_abort", 0, 16'(busy[0]), 16'd0);

    // Single-term accumulation.
    go(2); feed(2, 16'h1234, 1'b1);
    wait_done(2, 16'h1234, "n1");
    accept(2);

    // Random traffic on all instances; the per-cycle model does the checking.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < ND; d++) begin
        start[d]     = $urandom_range(0, 3) == 0;
        abort[d]     = $urandom_range(0, 63) == 0;
        in_valid[d]  = $urandom_range(0, 3) != 0;
        in_v[d]      = $urandom_range(0, 1) == 1;
        in_w[d]      = 16'($urandom);
        out_ready[d] = $urandom_range(0, 1) == 1;
      end
      step();
    end
    start = '0; abort = '0; in_valid = '0; out_ready = '0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
